// File: rtl/par2serial_8b_tx.sv
// Parallel-to-serial transmit stage: shifts one 8-bit word out MSB-first every 8 clk_32f cycles.
// After reset it sends ALIGN_WORDS idle symbols, then frames user words and fills empty slots with IDLE_SYM.
module par2serial_8b_tx #(
  parameter logic [7:0] IDLE_SYM    = 8'hBC,
  parameter int         ALIGN_WORDS = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       load_ack,
  output logic       data_out,
  output logic       active
);

  localparam int CNT_W = (ALIGN_WORDS > 1) ? $clog2(ALIGN_WORDS) : 1;
  localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_WORDS - 1);

  typedef enum logic {
    ALIGN  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] align_cnt;
  logic [7:0]       shreg;

  logic load_edge;
  logic align_done;

  assign load_edge  = (bit_cnt == 3'd7);
  assign align_done = load_edge && (state == ALIGN) && (align_cnt == ALIGN_LAST);

  // Alignment words are always idle; once active an empty slot is padded with the idle symbol.
  function automatic logic [7:0] select_symbol(input state_t st, input logic vld,
                                               input logic [7:0] word);
    if ((st == ACTIVE) && vld) return word;
    return IDLE_SYM;
  endfunction

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      shreg     <= 8'h00;
      bit_cnt   <= 3'd7;
      align_cnt <= '0;
      state     <= ALIGN;
      load_ack  <= 1'b0;
      active    <= 1'b0;
    end else begin
      // load_ack is registered one cycle early so it is high exactly while bit_cnt==7.
      load_ack <= (bit_cnt == 3'd6) && (state == ACTIVE);
      active   <= (state == ACTIVE) || align_done;
      if (load_edge) begin
        shreg   <= select_symbol(state, valid_in, data_in);
        bit_cnt <= 3'd0;
        if (state == ALIGN) begin
          if (align_cnt == ALIGN_LAST) begin
            state <= ACTIVE;
          end else begin
            align_cnt <= align_cnt + 1'b1;
          end
        end
      end else begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign data_out = shreg[7];

endmodule

// File: tb/tb_par2serial_8b_tx.sv
// Randomized scoreboard bench for par2serial_8b_tx: a word-level model predicts every output
// cycle, a negedge monitor compares. Two instances cover ALIGN_WORDS=4 and ALIGN_WORDS=1.
module tb_par2serial_8b_tx;

  localparam logic [7:0] IDLE = 8'hBC;

  typedef struct {
    logic d;
    logic act;
    logic ack;
  } exp_t;

  logic       clk_32f = 1'b0;
  logic       rst_a_n;
  logic       rst_b_n;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ack_a, dout_a, act_a;
  logic       ack_b, dout_b, act_b;
  logic       sel;

  logic       rst_sel, ack_sel, dout_sel, act_sel;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];

  always #5 clk_32f = ~clk_32f;

  par2serial_8b_tx #(.IDLE_SYM(8'hBC), .ALIGN_WORDS(4)) dut_a (
    .clk_32f (clk_32f),
    .reset_L (rst_a_n),
    .data_in (data_in),
    .valid_in(valid_in),
    .load_ack(ack_a),
    .data_out(dout_a),
    .active  (act_a)
  );

  par2serial_8b_tx #(.IDLE_SYM(8'hBC), .ALIGN_WORDS(1)) dut_b (
    .clk_32f (clk_32f),
    .reset_L (rst_b_n),
    .data_in (data_in),
    .valid_in(valid_in),
    .load_ack(ack_b),
    .data_out(dout_b),
    .active  (act_b)
  );

  assign rst_sel  = sel ? rst_b_n : rst_a_n;
  assign ack_sel  = sel ? ack_b   : ack_a;
  assign dout_sel = sel ? dout_b  : dout_a;
  assign act_sel  = sel ? act_b   : act_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock cycle while the selected DUT is out of reset.
  always @(negedge clk_32f) begin
    exp_t e;
    if (rst_sel) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow at %0t: got empty queue expected an entry", $time);
      end else begin
        e = sb_q.pop_front();
        check("data_out", {31'd0, dout_sel}, {31'd0, e.d});
        check("active",   {31'd0, act_sel},  {31'd0, e.act});
        check("load_ack", {31'd0, ack_sel},  {31'd0, e.ack});
      end
    end
  end

  task automatic set_reset(input logic v);
    if (sel) rst_b_n = v;
    else     rst_a_n = v;
  endtask

  // Word k after reset: the first ALIGN_WORDS words are idle, then each slot carries the
  // word presented at its load edge, or idle when valid_in is low.
  task automatic run_seq(input int aw, input int nwords, input int rst_word);
    int         k = 0;
    int         left = nwords;
    bit         first = 1'b1;
    logic [7:0] d, mid, sym;
    logic       v;
    bit         mid_en;
    exp_t       e;
    @(negedge clk_32f);
    #1;
    set_reset(1'b1);
    while (left > 0) begin
      d = 8'($urandom);
      v = 1'($urandom_range(0, 1));
      mid = 8'h00;
      mid_en = 1'b0;
      if (first && aw == 4) begin
        if (k == 4) begin d = 8'hA5; v = 1'b1; end
        if (k == 5) begin d = 8'hFF; v = 1'b0; end
        if (k == 6) begin d = 8'h3C; v = 1'b1; mid = 8'hC3; mid_en = 1'b1; end
        if (k == 7) begin d = 8'hC3; v = 1'b1; end
      end
      if (aw == 1 && k == 1) begin d = 8'h81; v = 1'b1; end
      data_in  = d;
      valid_in = v;
      sym = (k < aw || !v) ? IDLE : d;
      for (int b = 0; b < 8; b++) begin
        e.d   = sym[7-b];
        e.act = (k >= aw - 1);
        e.ack = (b == 7) && (k + 1 >= aw);
        sb_q.push_back(e);
      end
      @(posedge clk_32f);
      if (first && k == rst_word) begin
        repeat (4) @(posedge clk_32f);
        #2;
        set_reset(1'b0);
        #1;
        check("rst_mid_data_out", {31'd0, dout_sel}, 32'd0);
        check("rst_mid_load_ack", {31'd0, ack_sel},  32'd0);
        check("rst_mid_active",   {31'd0, act_sel},  32'd0);
        sb_q.delete();
        @(negedge clk_32f);
        #1;
        set_reset(1'b1);
        k = 0;
        first = 1'b0;
        continue;
      end
      for (int j = 0; j < 8; j++) begin
        @(negedge clk_32f);
        if (j < 7) begin
          data_in  = (mid_en && j == 3) ? mid : 8'($urandom);
          valid_in = 1'($urandom_range(0, 1));
        end
      end
      #1;
      k++;
      left--;
    end
    check("scoreboard_drained", sb_q.size(), 32'd0);
    set_reset(1'b0);
    #1;
    check("rst_end_data_out", {31'd0, dout_sel}, 32'd0);
    check("rst_end_active",   {31'd0, act_sel},  32'd0);
    sb_q.delete();
  endtask

  initial begin
    rst_a_n  = 1'b0;
    rst_b_n  = 1'b0;
    sel      = 1'b0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    repeat (3) @(negedge clk_32f);
    check("reset_a_data_out", {31'd0, dout_a}, 32'd0);
    check("reset_a_load_ack", {31'd0, ack_a},  32'd0);
    check("reset_a_active",   {31'd0, act_a},  32'd0);
    check("reset_b_data_out", {31'd0, dout_b}, 32'd0);
    check("reset_b_load_ack", {31'd0, ack_b},  32'd0);
    check("reset_b_active",   {31'd0, act_b},  32'd0);
    sel = 1'b0;
    run_seq(4, 14, 9);
    repeat (2) @(negedge clk_32f);
    sel = 1'b1;
    run_seq(1, 10, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog at %0t: got no completion expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
